// File: rtl/clk_rst_seq_pkg.sv
// Shared types and constants for the PLL lock / reset / clock-enable sequencer.
package clk_rst_seq_pkg;

  localparam int SEQ_STATE_W = 2;
  localparam int LOSS_CNT_W  = 8;

  localparam logic [LOSS_CNT_W-1:0] LOSS_CNT_MAX = '1;

  typedef enum logic [SEQ_STATE_W-1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } seq_state_t;

  // Channel-select width; a single channel still gets a 1-bit select.
  function automatic int ch_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/clk_rst_seq_if.sv
// Control/status bundle between the sequencer and its host.
// master: host side (drives lock, divisor writes, loss clear); slave: sequencer side.
interface clk_rst_seq_if
  import clk_rst_seq_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 16
) ();

  localparam int CH_W = ch_width(NUM_CH);

  logic                  pll_locked;
  logic                  div_wr;
  logic [CH_W-1:0]       div_ch;
  logic [DIV_W-1:0]      div_val;
  logic                  loss_clr;
  logic [NUM_CH-1:0]     rst_out;
  logic [NUM_CH-1:0]     ce;
  logic                  clk_ok;
  logic [SEQ_STATE_W-1:0] seq_state;
  logic [LOSS_CNT_W-1:0] loss_cnt;
  logic                  loss_flag;

  modport master (
    output pll_locked, div_wr, div_ch, div_val, loss_clr,
    input  rst_out, ce, clk_ok, seq_state, loss_cnt, loss_flag
  );

  modport slave (
    input  pll_locked, div_wr, div_ch, div_val, loss_clr,
    output rst_out, ce, clk_ok, seq_state, loss_cnt, loss_flag
  );

endinterface

// File: rtl/clk_rst_seq_clk_en_div.sv
// Per-channel clock-enable divider: counts 0..div and strobes ce on the
// terminal count. A new divisor sits in a shadow register and only becomes
// active at a wrap (or at once while the channel is held in reset), so a
// running period is never cut short.
module clk_en_div #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ch_rst,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_val,
  output logic             ce
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_act;
  logic [DIV_W-1:0] div_shadow;
  logic [DIV_W-1:0] div_next;
  logic             wrap;

  // A write landing in the wrap cycle is taken directly so the newest value wins.
  assign div_next = wr ? wr_val : div_shadow;
  assign wrap     = (cnt == div_act);
  assign ce       = ~ch_rst & wrap;

  // Shadow capture, active-divisor transfer and period counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      div_act    <= '0;
      div_shadow <= '0;
    end else begin
      if (wr) begin
        div_shadow <= wr_val;
      end
      if (ch_rst || wrap) begin
        cnt     <= '0;
        div_act <= div_next;
      end else begin
        cnt <= cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/clk_rst_seq.sv
// PLL lock qualifier and staggered reset / clock-enable sequencer.
// Optional feature macro: CLK_RST_SEQ_LOSS_CNT_EN enables the saturating
// lock-loss counter and sticky loss flag; without it both read as zero.
//
// state     | meaning
// WAIT_LOCK | all channels in reset, waiting for synchronised lock
// SETTLE    | lock seen, counting LOCK_CYC stable cycles
// RELEASE   | deasserting channel resets STAGGER cycles apart
// RUN       | all channels out of reset, clk_ok high
module clk_rst_seq
  import clk_rst_seq_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 16,
  parameter int LOCK_CYC    = 1024,
  parameter int STAGGER     = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic          clk,
  input logic          rst,
  clk_rst_seq_if.slave bus
);

  localparam int CH_W     = ch_width(NUM_CH);
  localparam int SETTLE_W = $clog2(LOCK_CYC);
  localparam int REL_W    = $clog2(NUM_CH * STAGGER + 1);

  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(LOCK_CYC - 1);
  localparam logic [REL_W-1:0]    REL_LAST    = REL_W'((NUM_CH - 1) * STAGGER);
  localparam logic [NUM_CH-1:0]   CH0_ONLY    = NUM_CH'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;

  seq_state_t             state;
  logic [SETTLE_W-1:0]    settle_cnt;
  logic [REL_W-1:0]       rel_cnt;
  logic [REL_W-1:0]       rel_next;
  logic [NUM_CH-1:0]      rel_mask;
  logic [NUM_CH-1:0]      rst_q;
  logic                   clk_ok_q;

  logic                   div_ch_ok;
  logic [NUM_CH-1:0]      ce_w;

  // Lock synchroniser; every sequencing decision uses the last stage only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pll_locked};
    end
  end

  assign locked_s = sync_q[SYNC_STAGES-1];

  // Reset pattern for the cycle after the release counter advances:
  // channel i stays in reset until i*STAGGER cycles after RELEASE entry.
  always_comb begin
    rel_next = rel_cnt + REL_W'(1);
    rel_mask = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      rel_mask[i] = (32'(rel_next) < 32'(i * STAGGER));
    end
  end

  // Sequencer FSM with settle/stagger counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= WAIT_LOCK;
      settle_cnt <= '0;
      rel_cnt    <= '0;
      rst_q      <= '1;
      clk_ok_q   <= 1'b0;
    end else begin
      case (state)
        WAIT_LOCK: begin
          settle_cnt <= '0;
          rel_cnt    <= '0;
          if (locked_s) begin
            state <= SETTLE;
          end
        end
        SETTLE: begin
          if (!locked_s) begin
            state      <= WAIT_LOCK;
            settle_cnt <= '0;
          end else if (settle_cnt == SETTLE_LAST) begin
            state   <= RELEASE;
            rel_cnt <= '0;
            rst_q   <= ~CH0_ONLY;
          end else begin
            settle_cnt <= settle_cnt + SETTLE_W'(1);
          end
        end
        RELEASE: begin
          if (!locked_s) begin
            state      <= WAIT_LOCK;
            settle_cnt <= '0;
            rst_q      <= '1;
            clk_ok_q   <= 1'b0;
          end else if (rel_cnt == REL_LAST) begin
            state    <= RUN;
            clk_ok_q <= 1'b1;
          end else begin
            rel_cnt <= rel_next;
            rst_q   <= rel_mask;
          end
        end
        RUN: begin
          if (!locked_s) begin
            state      <= WAIT_LOCK;
            settle_cnt <= '0;
            rst_q      <= '1;
            clk_ok_q   <= 1'b0;
          end
        end
        default: begin
          state    <= WAIT_LOCK;
          rst_q    <= '1;
          clk_ok_q <= 1'b0;
        end
      endcase
    end
  end

  // Selects that do not name an existing channel are dropped.
  assign div_ch_ok = (32'(bus.div_ch) < 32'(NUM_CH));

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic wr_ch;
    assign wr_ch = bus.div_wr & div_ch_ok & (bus.div_ch == CH_W'(g));

    clk_en_div #(
      .DIV_W (DIV_W)
    ) u_div (
      .clk    (clk),
      .rst    (rst),
      .ch_rst (rst_q[g]),
      .wr     (wr_ch),
      .wr_val (bus.div_val),
      .ce     (ce_w[g])
    );
  end

  assign bus.rst_out   = rst_q;
  assign bus.ce        = ce_w;
  assign bus.clk_ok    = clk_ok_q;
  assign bus.seq_state = state;

`ifdef CLK_RST_SEQ_LOSS_CNT_EN
  logic [LOSS_CNT_W-1:0] loss_cnt_q;
  logic                  loss_flag_q;
  logic                  loss_ev;

  // Only a drop out of RUN counts; a clear coinciding with a loss leaves that loss counted.
  assign loss_ev = (state == RUN) && !locked_s;

  // Saturating loss counter and sticky flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loss_cnt_q  <= '0;
      loss_flag_q <= 1'b0;
    end else if (loss_ev) begin
      loss_flag_q <= 1'b1;
      if (bus.loss_clr) begin
        loss_cnt_q <= LOSS_CNT_W'(1);
      end else if (loss_cnt_q != LOSS_CNT_MAX) begin
        loss_cnt_q <= loss_cnt_q + LOSS_CNT_W'(1);
      end
    end else if (bus.loss_clr) begin
      loss_cnt_q  <= '0;
      loss_flag_q <= 1'b0;
    end
  end

  assign bus.loss_cnt  = loss_cnt_q;
  assign bus.loss_flag = loss_flag_q;
`else
  logic unused_loss_clr;
  assign unused_loss_clr = bus.loss_clr;
  assign bus.loss_cnt    = '0;
  assign bus.loss_flag   = 1'b0;
`endif

endmodule

// File: tb/tb_clk_rst_seq.sv
// Scoreboard bench for clk_rst_seq: stimulus pushes cycle-stamped expected
// values, a negedge monitor pops and compares them.
// Instance b: default parameters. Instance s: NUM_CH=3, LOCK_CYC=4, STAGGER=2.
module tb_clk_rst_seq;
  import clk_rst_seq_pkg::*;

`ifdef CLK_RST_SEQ_LOSS_CNT_EN
  localparam int LOSS_EN = 1;
`else
  localparam int LOSS_EN = 0;
`endif

  localparam int F_RST = 0, F_CE = 1, F_OK = 2, F_ST = 3, F_LCNT = 4, F_LFLAG = 5;
  localparam int S_RST = 6, S_CE = 7, S_OK = 8, S_ST = 9, S_LCNT = 10, S_LFLAG = 11;

  typedef struct {
    int         cyc;
    int         fld;
    logic [7:0] val;
    string      name;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   stim_done = 1'b0;
  bit   end_checked = 1'b0;
  exp_t exp_q[$];

  clk_rst_seq_if #(.NUM_CH(4), .DIV_W(16)) bus_b ();
  clk_rst_seq_if #(.NUM_CH(3), .DIV_W(8))  bus_s ();

  clk_rst_seq #(
    .NUM_CH(4), .DIV_W(16), .LOCK_CYC(1024), .STAGGER(16), .SYNC_STAGES(2)
  ) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  clk_rst_seq #(
    .NUM_CH(3), .DIV_W(8), .LOCK_CYC(4), .STAGGER(2), .SYNC_STAGES(2)
  ) u_dut_s (
    .clk (clk),
    .rst (rst),
    .bus (bus_s)
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges since reset was released
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic logic [7:0] actual(input int f);
    case (f)
      F_RST:   return 8'(bus_b.rst_out);
      F_CE:    return 8'(bus_b.ce);
      F_OK:    return 8'(bus_b.clk_ok);
      F_ST:    return 8'(bus_b.seq_state);
      F_LCNT:  return bus_b.loss_cnt;
      F_LFLAG: return 8'(bus_b.loss_flag);
      S_RST:   return 8'(bus_s.rst_out);
      S_CE:    return 8'(bus_s.ce);
      S_OK:    return 8'(bus_s.clk_ok);
      S_ST:    return 8'(bus_s.seq_state);
      S_LCNT:  return bus_s.loss_cnt;
      default: return 8'(bus_s.loss_flag);
    endcase
  endfunction

  // Insert keeping the queue ordered by cycle.
  task automatic push(input int c, input int f, input int v, input string nm);
    exp_t e;
    int   i;
    e.cyc = c; e.fld = f; e.val = 8'(v); e.name = nm;
    i = exp_q.size();
    while (i > 0 && exp_q[i-1].cyc > c) i--;
    exp_q.insert(i, e);
  endtask

  // Returns 1 time unit after rising edge n; inputs set then are seen at edge n+1.
  task automatic at_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr_div(input int at, input int ch, input int val);
    at_cyc(at);
    bus_b.div_wr  = 1'b1;
    bus_b.div_ch  = 2'(ch);
    bus_b.div_val = 16'(val);
    at_cyc(at + 1);
    bus_b.div_wr  = 1'b0;
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    logic [7:0] a;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      a = actual(e.fld);
      n_chk++;
      if (e.cyc != cyc || a !== e.val) begin
        n_fail++;
        $display("FAIL %s @cyc %0d (now %0d): got 'h%0h expected 'h%0h", e.name, e.cyc, cyc, a, e.val);
      end
    end
    if (stim_done && !end_checked) begin
      end_checked = 1'b1;
      n_chk++;
      if (exp_q.size() != 0) begin
        n_fail++;
        $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
      end
    end
  end

  initial begin
    #150000;
    $display("FAIL watchdog: got timeout expected completion by cyc 8767");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int sat;
    bus_b.pll_locked = 1'b1; bus_b.div_wr = 1'b0; bus_b.div_ch = '0;
    bus_b.div_val = '0;      bus_b.loss_clr = 1'b0;
    bus_s.pll_locked = 1'b0; bus_s.div_wr = 1'b0; bus_s.div_ch = '0;
    bus_s.div_val = '0;      bus_s.loss_clr = 1'b0;

    // reset values
    push(0, F_RST, 'hF, "rst_rst_out"); push(0, F_CE, 0, "rst_ce");
    push(0, F_OK, 0, "rst_clk_ok");     push(0, F_ST, 0, "rst_state");
    push(0, F_LCNT, 0, "rst_loss_cnt"); push(0, F_LFLAG, 0, "rst_loss_flag");
    push(0, S_RST, 'h7, "s_rst_rst_out"); push(0, S_ST, 0, "s_rst_state");

    // Lock high from reset: 2 sync edges, 1 WAIT_LOCK decision -> SETTLE at 3,
    // 1024 settle cycles -> RELEASE at 1027, channels at +0/+16/+32/+48, RUN at +49.
    push(2, F_ST, 0, "a_wait_sync");    push(3, F_ST, 1, "a_settle_entry");
    push(1026, F_ST, 1, "a_settle_last"); push(1026, F_RST, 'hF, "a_rst_pre");
    push(1027, F_ST, 2, "a_release");   push(1027, F_RST, 'hE, "a_rst0_fall");
    push(1027, F_CE, 'h1, "a_ce_div0"); push(1027, F_OK, 0, "a_ok_release");
    push(1042, F_RST, 'hE, "a_rst1_hold"); push(1043, F_RST, 'hC, "a_rst1_fall");
    push(1043, F_CE, 'h3, "a_ce_ch1");  push(1059, F_RST, 'h8, "a_rst2_fall");
    push(1059, F_CE, 'h7, "a_ce_ch2");  push(1075, F_RST, 'h0, "a_rst3_fall");
    push(1075, F_CE, 'hF, "a_ce_ch3");  push(1075, F_OK, 0, "a_ok_late");
    push(1075, F_ST, 2, "a_still_rel"); push(1076, F_ST, 3, "a_run");
    push(1076, F_OK, 1, "a_ok_run");
    #22 rst = 1'b0;

    // ch0 div 4 (period 5), then 9 mid-period, then 7 and 2 back to back
    at_cyc(1079);
    push(1080, F_CE, 'hF, "b_div0"); push(1081, F_CE, 'hE, "b_div4_load");
    push(1084, F_CE, 'hE, "b_p5_a");  push(1085, F_CE, 'hF, "b_p5_ce1");
    push(1086, F_CE, 'hE, "b_p5_b");  push(1090, F_CE, 'hF, "b_p5_ce2");
    push(1095, F_CE, 'hF, "b_old_period_done"); push(1096, F_CE, 'hE, "b_p10_a");
    push(1100, F_CE, 'hE, "b_p10_no_old"); push(1104, F_CE, 'hE, "b_p10_b");
    push(1105, F_CE, 'hF, "b_p10_ce");  push(1106, F_CE, 'hE, "b_p10_c");
    push(1115, F_CE, 'hF, "b_p10_ce2"); push(1125, F_CE, 'hF, "b_p10_ce3");
    push(1126, F_CE, 'hE, "b_lww_a");   push(1127, F_CE, 'hE, "b_lww_b");
    push(1128, F_CE, 'hF, "b_lww_ce");  push(1130, F_CE, 'hE, "b_lww_c");
    push(1131, F_CE, 'hF, "b_lww_ce2");
    wr_div(1080, 0, 4);
    wr_div(1092, 0, 9);
    wr_div(1116, 0, 7);
    wr_div(1117, 0, 2);

    // lock loss in RUN
    at_cyc(1139);
    push(1142, F_ST, 3, "c_run_pre");  push(1142, F_RST, 0, "c_rst_pre");
    push(1142, F_OK, 1, "c_ok_pre");   push(1142, F_CE, 'hE, "c_ce_pre");
    push(1143, F_ST, 0, "c_loss_state"); push(1143, F_RST, 'hF, "c_loss_rst");
    push(1143, F_CE, 0, "c_loss_ce");  push(1143, F_OK, 0, "c_loss_ok");
    push(1143, F_LCNT, LOSS_EN, "c_loss_cnt"); push(1143, F_LFLAG, LOSS_EN, "c_loss_flag");
    at_cyc(1140); bus_b.pll_locked = 1'b0;

    // relock, drop at settle count 500, relock for a full settle
    at_cyc(1150); bus_b.pll_locked = 1'b1;
    push(1152, F_ST, 0, "d_wait_sync"); push(1153, F_ST, 1, "d_settle");
    push(1653, F_ST, 1, "d_settle_500"); push(1654, F_ST, 0, "d_drop_wait");
    push(1654, F_RST, 'hF, "d_drop_rst");
    at_cyc(1651); bus_b.pll_locked = 1'b0;
    at_cyc(1660); bus_b.pll_locked = 1'b1;
    push(1700, F_ST, 1, "d_resettle"); push(2686, F_ST, 1, "d_settle_full");
    push(2686, F_RST, 'hF, "d_rst_pre"); push(2687, F_ST, 2, "d_release");
    push(2687, F_RST, 'hE, "d_rst0_fall"); push(2687, F_CE, 0, "d_ce_first_a");
    push(2687, F_LCNT, LOSS_EN, "d_loss_cnt_keep");
    push(2688, F_CE, 0, "d_ce_first_b"); push(2689, F_CE, 'h1, "d_ce_first_strobe");
    push(2690, F_CE, 0, "d_ce_p3");      push(2703, F_RST, 'hC, "d_rst1");
    push(2703, F_CE, 'h2, "d_ce_ch1");   push(2719, F_RST, 'h8, "d_rst2");
    push(2719, F_CE, 'h7, "d_ce_ch2");   push(2735, F_RST, 0, "d_rst3");
    push(2735, F_CE, 'hE, "d_ce_ch3");   push(2735, F_ST, 2, "d_still_rel");
    push(2736, F_ST, 3, "d_run");        push(2736, F_OK, 1, "d_ok");
    push(2736, F_CE, 'hE, "d_ce_run");

    // second loss with loss_clr in the same cycle, then a plain clear
    at_cyc(2739);
    push(2742, F_ST, 3, "e_run_pre");    push(2742, F_LCNT, LOSS_EN, "e_cnt_pre");
    push(2743, F_ST, 0, "e_loss_state"); push(2743, F_LCNT, LOSS_EN, "e_clr_and_loss_cnt");
    push(2743, F_LFLAG, LOSS_EN, "e_clr_and_loss_flag"); push(2745, F_LCNT, LOSS_EN, "e_cnt_hold");
    push(2746, F_LCNT, 0, "e_clr_cnt");  push(2746, F_LFLAG, 0, "e_clr_flag");
    at_cyc(2740); bus_b.pll_locked = 1'b0;
    at_cyc(2742); bus_b.loss_clr = 1'b1;
    at_cyc(2743); bus_b.loss_clr = 1'b0;
    at_cyc(2745); bus_b.loss_clr = 1'b1;
    at_cyc(2746); bus_b.loss_clr = 1'b0;

    // small instance: out-of-range divisor select is dropped
    at_cyc(2755);
    bus_s.div_wr = 1'b1; bus_s.div_ch = 2'd3; bus_s.div_val = 8'd5;
    push(2756, S_ST, 0, "s_wait"); push(2756, S_RST, 'h7, "s_rst_wait");
    at_cyc(2756); bus_s.div_wr = 1'b0;

    // 300 lock/loss cycles: SETTLE t+3, RELEASE t+7, RUN t+12, loss edge t+16
    for (int k = 1; k <= 300; k++) begin
      t = 2760 + 20 * (k - 1);
      sat = (k > 255) ? 255 : k;
      at_cyc(t);
      push(t + 6, S_ST, 1, "s_settle");  push(t + 7, S_ST, 2, "s_release");
      push(t + 15, S_ST, 3, "s_run_pre"); push(t + 16, S_ST, 0, "s_loss_state");
      push(t + 16, S_RST, 'h7, "s_loss_rst");
      push(t + 16, S_LCNT, sat * LOSS_EN, "s_loss_cnt_sat");
      push(t + 16, S_LFLAG, LOSS_EN, "s_loss_flag");
      if (k == 1) begin
        push(t + 7, S_RST, 'h6, "s_rst0");  push(t + 7, S_CE, 'h1, "s_ce0");
        push(t + 9, S_RST, 'h4, "s_rst1");  push(t + 9, S_CE, 'h3, "s_ce1");
        push(t + 11, S_RST, 0, "s_rst2");   push(t + 11, S_OK, 0, "s_ok_rel");
        push(t + 12, S_OK, 1, "s_ok_run");  push(t + 12, S_CE, 'h7, "s_ce_div0_kept");
        push(t + 16, S_OK, 0, "s_ok_loss"); push(t + 16, S_CE, 0, "s_ce_loss");
      end
      bus_s.pll_locked = 1'b1;
      at_cyc(t + 13);
      bus_s.pll_locked = 1'b0;
    end

    at_cyc(8760);
    push(8760, S_LCNT, 255 * LOSS_EN, "s_cnt_saturated");
    push(8761, S_LCNT, 0, "s_clr_cnt"); push(8761, S_LFLAG, 0, "s_clr_flag");
    bus_s.loss_clr = 1'b1;
    at_cyc(8761); bus_s.loss_clr = 1'b0;

    at_cyc(8765);
    stim_done = 1'b1;
    at_cyc(8767);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
